// File: rtl/muldiv_unit_pkg.sv
// Shared constants for the multiply/divide unit: ALU control codes and FSM state encoding.
package muldiv_unit_pkg;

   localparam logic [3:0] ALU_MULT = 4'b1010;
   localparam logic [3:0] ALU_DIV  = 4'b1111;
   localparam logic [3:0] ALU_MFHI = 4'b0101;
   localparam logic [3:0] ALU_MFLO = 4'b0111;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_MUL   = 2'd1;
   localparam logic [1:0] ST_DIV   = 2'd2;
   localparam logic [1:0] ST_FIXUP = 2'd3;

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation; with neg tied to the sign bit it yields the magnitude.
module muldiv_signfix #(
   parameter int N = 32
) (
   input  logic [N-1:0] val,
   input  logic         neg,
   output logic [N-1:0] res
);

   assign res = neg ? (~val + N'(1)) : val;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle signed multiply/divide unit owning HI/LO; iterative shift-add mult and restoring div.
// Define MULDIV_FAST_MULT_EN to compute mult in a single MUL cycle instead of WIDTH iterations.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       ALUInput,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic [WIDTH-1:0] Result
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [1:0]         state;
   logic [CW-1:0]      count;
   // acc_hi/acc_lo hold {product} for mult, {remainder, shifting dividend/quotient} for div
   logic [WIDTH-1:0]   acc_hi;
   logic [WIDTH-1:0]   acc_lo;
   logic [WIDTH-1:0]   opd;
   logic               is_div;
   logic               sign_q;
   logic               sign_r;
   logic               div0;

   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic               last_iter;

   muldiv_signfix #(.N(WIDTH)) u_abs_a (.val(A), .neg(A[WIDTH-1]), .res(abs_a));
   muldiv_signfix #(.N(WIDTH)) u_abs_b (.val(B), .neg(B[WIDTH-1]), .res(abs_b));
   muldiv_signfix #(.N(2*WIDTH)) u_fix_prod (.val({acc_hi, acc_lo}), .neg(sign_q), .res(prod_fix));
   // A zero divisor leaves the all-ones quotient un-negated; the remainder then equals A.
   muldiv_signfix #(.N(WIDTH)) u_fix_quo (.val(acc_lo), .neg(sign_q & ~div0), .res(quo_fix));
   muldiv_signfix #(.N(WIDTH)) u_fix_rem (.val(acc_hi), .neg(sign_r), .res(rem_fix));

   assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, opd};
   assign last_iter = (count == CW'(WIDTH - 1));

`ifdef MULDIV_FAST_MULT_EN
   logic [2*WIDTH-1:0] fast_prod;
   assign fast_prod = {{WIDTH{1'b0}}, opd} * {{WIDTH{1'b0}}, acc_lo};
`else
   logic [WIDTH:0]     mul_sum;
   assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : {(WIDTH+1){1'b0}});
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         count  <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         opd    <= '0;
         is_div <= 1'b0;
         sign_q <= 1'b0;
         sign_r <= 1'b0;
         div0   <= 1'b0;
         HI     <= '0;
         LO     <= '0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               count <= '0;
               if (start && ALUInput == ALU_MULT) begin
                  opd    <= abs_a;
                  acc_lo <= abs_b;
                  acc_hi <= '0;
                  is_div <= 1'b0;
                  sign_q <= A[WIDTH-1] ^ B[WIDTH-1];
                  sign_r <= 1'b0;
                  div0   <= 1'b0;
                  state  <= ST_MUL;
               end else if (start && ALUInput == ALU_DIV) begin
                  opd    <= abs_b;
                  acc_lo <= abs_a;
                  acc_hi <= '0;
                  is_div <= 1'b1;
                  sign_q <= A[WIDTH-1] ^ B[WIDTH-1];
                  sign_r <= A[WIDTH-1];
                  div0   <= (B == '0);
                  state  <= ST_DIV;
               end
            end
            ST_MUL: begin
`ifdef MULDIV_FAST_MULT_EN
               {acc_hi, acc_lo} <= fast_prod;
               state            <= ST_FIXUP;
`else
               {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
               count            <= count + CW'(1);
               if (last_iter) begin
                  count <= '0;
                  state <= ST_FIXUP;
               end
`endif
            end
            ST_DIV: begin
               if (!div_diff[WIDTH]) begin
                  acc_hi <= div_diff[WIDTH-1:0];
                  acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
               end else begin
                  acc_hi <= div_shift[WIDTH-1:0];
                  acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
               end
               count <= count + CW'(1);
               if (last_iter) begin
                  count <= '0;
                  state <= ST_FIXUP;
               end
            end
            ST_FIXUP: begin
               if (is_div) begin
                  LO <= quo_fix;
                  HI <= rem_fix;
               end else begin
                  {HI, LO} <= prod_fix;
               end
               done  <= 1'b1;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy = (state != ST_IDLE);

   always_comb begin
      Result = '0;
      case (ALUInput)
         ALU_MFHI: Result = HI;
         ALU_MFLO: Result = LO;
         default:  Result = '0;
      endcase
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random mult/div against an arithmetic model.
module tb_muldiv_unit;

   localparam int W = 32;
`ifdef MULDIV_FAST_MULT_EN
   localparam int MUL_LAT = 2;
`else
   localparam int MUL_LAT = W + 1;
`endif
   localparam int DIV_LAT = W + 1;

   localparam logic [3:0] C_MULT = 4'b1010;
   localparam logic [3:0] C_DIV  = 4'b1111;
   localparam logic [3:0] C_MFHI = 4'b0101;
   localparam logic [3:0] C_MFLO = 4'b0111;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [3:0]   ALUInput = 4'b0000;
   logic         start = 1'b0;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] HI;
   logic [W-1:0] LO;
   logic [W-1:0] Result;

   int errors = 0;
   int checks = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] ref_hi = '0;
   logic [W-1:0] ref_lo = '0;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .ALUInput(ALUInput), .start(start),
      .A(A), .B(B), .busy(busy), .done(done), .HI(HI), .LO(LO), .Result(Result)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   // reference model: plain signed arithmetic, pushes expected {hi, lo}
   task automatic ref_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic signed [63:0] pa, pb, p, q, r;
      pa = {{32{a[W-1]}}, a};
      pb = {{32{b[W-1]}}, b};
      if (op == C_MULT) begin
         p = pa * pb;
         ref_hi = p[63:32];
         ref_lo = p[31:0];
      end else if (b == '0) begin
         ref_hi = a;
         ref_lo = '1;
      end else begin
         q = pa / pb;
         r = pa % pb;
         ref_hi = r[31:0];
         ref_lo = q[31:0];
      end
      exp_q.push_back(ref_hi);
      exp_q.push_back(ref_lo);
   endtask

   // driver: issue one operation and check latency, handshake, HI/LO and mfhi/mflo
   task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int exp_lat, input bit inject, input string name);
      logic [W-1:0] eh, el, prev_hi;
      int n;
      bit busy_bad, overlap, stale_bad;
      prev_hi = ref_hi;
      ref_op(op, a, b);
      eh = exp_q.pop_front();
      el = exp_q.pop_front();
      start = 1'b1; ALUInput = op; A = a; B = b;
      @(posedge clk); #1;
      start = 1'b0; ALUInput = 4'b0000; A = $urandom; B = $urandom;
      n = 0; busy_bad = 0; overlap = 0; stale_bad = 0;
      while (!done && n < 200) begin
         if (!busy) busy_bad = 1;
         if (n == 1) begin
            ALUInput = C_MFHI; #1;
            if (Result !== prev_hi) stale_bad = 1;
            ALUInput = 4'b0000;
         end
         start = (inject && n == 3);
         if (start) begin
            ALUInput = C_DIV; A = 32'd100; B = 32'd7;
         end
         @(posedge clk); #1;
         start = 1'b0; ALUInput = 4'b0000;
         n++;
         if (busy && done) overlap = 1;
      end
      checks++;
      if (n !== exp_lat) begin
         errors++; $display("FAIL %s latency: got %0d edges, expected %0d", name, n, exp_lat);
      end
      checks++;
      if (busy_bad || overlap) begin
         errors++; $display("FAIL %s busy: busy_dropped=%0d busy_with_done=%0d, expected 0 0", name, busy_bad, overlap);
      end
      checks++;
      if (stale_bad) begin
         errors++; $display("FAIL %s stale_read: Result while busy differed from previous HI %h", name, prev_hi);
      end
      checks++;
      if (HI !== eh) begin
         errors++; $display("FAIL %s HI: got %h expected %h", name, HI, eh);
      end
      checks++;
      if (LO !== el) begin
         errors++; $display("FAIL %s LO: got %h expected %h", name, LO, el);
      end
      ALUInput = C_MFHI; #1;
      checks++;
      if (Result !== eh) begin
         errors++; $display("FAIL %s mfhi: got %h expected %h", name, Result, eh);
      end
      ALUInput = C_MFLO; #1;
      checks++;
      if (Result !== el) begin
         errors++; $display("FAIL %s mflo: got %h expected %h", name, Result, el);
      end
      ALUInput = 4'b0000;
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL %s done_width: done still %b one cycle later, expected 0", name, done);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      ref_hi = '0; ref_lo = '0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL reset_flags: busy=%b done=%b expected 0 0", busy, done);
      end
      checks++;
      if (HI !== '0 || LO !== '0) begin
         errors++; $display("FAIL reset_hilo: HI=%h LO=%h expected 0 0", HI, LO);
      end
      ALUInput = C_MFHI; #1;
      checks++;
      if (Result !== '0) begin
         errors++; $display("FAIL reset_mfhi: got %h expected 0", Result);
      end
      ALUInput = C_MFLO; #1;
      checks++;
      if (Result !== '0) begin
         errors++; $display("FAIL reset_mflo: got %h expected 0", Result);
      end
      ALUInput = 4'b0000;
   endtask

   task automatic test_mult();
      run_op(C_MULT, 32'd7, 32'hFFFF_FFFD, MUL_LAT, 1'b0, "mult_7_x_m3");
      run_op(C_MULT, 32'h8000_0000, 32'h8000_0000, MUL_LAT, 1'b0, "mult_min_x_min");
      run_op(C_MULT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 1'b0, "mult_max_x_m1");
   endtask

   task automatic test_div();
      run_op(C_DIV, 32'hFFFF_FFF9, 32'd2, DIV_LAT, 1'b1, "div_m7_by_2_inject");
      run_op(C_DIV, 32'd5, 32'd0, DIV_LAT, 1'b0, "div_by_zero");
      run_op(C_DIV, 32'hFFFF_FFFB, 32'd0, DIV_LAT, 1'b0, "div_neg_by_zero");
      run_op(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, 1'b0, "div_overflow");
   endtask

   task automatic test_result_mux();
      logic [3:0] codes[5];
      codes = '{4'b0000, 4'b0010, C_MULT, C_DIV, 4'b0110};
      for (int i = 0; i < 5; i++) begin
         ALUInput = codes[i]; #1;
         checks++;
         if (Result !== '0) begin
            errors++; $display("FAIL result_mux code %b: got %h expected 0", codes[i], Result);
         end
      end
      ALUInput = 4'b0000;
   endtask

   task automatic test_reset_mid_op();
      bit saw_done;
      start = 1'b1; ALUInput = C_MULT; A = 32'h7FFF_FFFF; B = 32'h7FFF_FFFF;
      @(posedge clk); #1;
      start = 1'b0; ALUInput = 4'b0000;
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      ref_hi = '0; ref_lo = '0;
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL midreset_busy: got %b expected 0", busy);
      end
      checks++;
      if (HI !== '0 || LO !== '0) begin
         errors++; $display("FAIL midreset_hilo: HI=%h LO=%h expected 0 0", HI, LO);
      end
      saw_done = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done) saw_done = 1;
      end
      checks++;
      if (saw_done) begin
         errors++; $display("FAIL midreset_done: got a done pulse, expected none");
      end
   endtask

   function automatic logic [W-1:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return '0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   task automatic test_random();
      logic [W-1:0] a, b;
      bit is_mult;
      for (int i = 0; i < 24; i++) begin
         a = pick_operand();
         b = pick_operand();
         is_mult = $urandom_range(0, 1);
         if (is_mult)
            run_op(C_MULT, a, b, MUL_LAT, 1'b0, $sformatf("rand%0d_mult", i));
         else
            run_op(C_DIV, a, b, DIV_LAT, 1'b0, $sformatf("rand%0d_div", i));
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_result_mux();
      test_reset_mid_op();
      test_random();
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL scoreboard: %0d expected entries left over", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multi-cycle multiply/divide execution unit that consumes the 4-bit ALU control code produced by the ALU control decoder. It services the mult (1010), div (1111), mfhi (0101) and mflo (0111) codes. It also owns the architectural HI/LO registers. It sits beside the single-cycle ALU in EX and raises busy so the pipeline control can stall while an iterative operation runs.

Parameters:
WIDTH, 32, operand width and HI/LO width; iteration count equals WIDTH.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
ALUInput  input  4  ALU control code from the ALU control decoder
start  input  1  operation request; qualifies ALUInput, A and B for one cycle
A  input  WIDTH  rs operand (multiplicand / dividend)
B  input  WIDTH  rt operand (multiplier / divisor)
busy  output  1  iterative operation in progress
done  output  1  one-cycle pulse; HI/LO updated on the same edge
HI  output  WIDTH  HI register
LO  output  WIDTH  LO register
Result  output  WIDTH  combinational mfhi/mflo read data

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset).
- Reset: state=IDLE, HI=0, LO=0, busy=0, done=0, counter=0. Reset mid-operation abandons the operation; HI/LO are not updated.
- States: IDLE, MUL, DIV, FIXUP.
- Accepting in IDLE:
  - start=1 and ALUInput=1010: capture |A|, |B| and the result sign; go to MUL.
  - start=1 and ALUInput=1111: capture |A|, |B|, quotient sign (A[msb]^B[msb]) and remainder sign (A[msb]); go to DIV.
  - Any other code, or start=0: stay in IDLE.
- start in any state other than IDLE is ignored. No queueing; the pipeline must honour busy.
- MUL: unsigned shift-add, one bit per cycle, WIDTH cycles, 2*WIDTH-bit product.
- DIV: unsigned restoring division, one quotient bit per cycle, WIDTH cycles.
- Transition: after WIDTH iterations, go to FIXUP.
- FIXUP:
  - Apply two's-complement negation per the captured signs.
  - Mult: HI=product[2W-1:W], LO=product[W-1:0].
  - Div: LO=quotient, HI=remainder.
  - done=1 for exactly this edge's following cycle; return to IDLE.
- Latency: accept edge T. done is high in the cycle after edge T+WIDTH+1. busy is high from T+1 through the cycle in which FIXUP executes. busy and done are never high together.
- Divide by zero: no trap. Run the full latency; LO=all ones, HI=A unmodified.
- Overflow: most-negative / -1 gives LO=0x80000000, HI=0 (natural truncated result; no special case).
- Result (combinational):
  - ALUInput=0101: Result=HI.
  - ALUInput=0111: Result=LO.
  - Otherwise: Result=0.
  - Result reflects registered HI/LO, so a read issued while busy returns stale values; stalling is the pipeline's duty.
- All arithmetic is signed two's complement. Intermediate magnitudes are WIDTH bits; the magnitude of the most-negative value is the same bit pattern treated as unsigned.

Optional Feature:
MULDIV_FAST_MULT_EN:
- Defined: mult is computed with a single-cycle signed WIDTH x WIDTH multiplier. MUL lasts one cycle, so done comes 2 edges after accept instead of WIDTH+1. Div is unchanged.
- Undefined: iterative shift-add multiply as above. Both variants give identical HI/LO values.

Decomposition:
- Shared package: ALU control code constants (ALU_MULT=4'b1010, ALU_DIV=4'b1111, ALU_MFHI=4'b0101, ALU_MFLO=4'b0111) and the state encoding.
- One natural sub-module, muldiv_signfix: combinational magnitude and negation helper, used at capture and at FIXUP.

Test Plan:
- Reset, then mfhi/mflo reads -> Result=0; busy=0, done=0.
- mult A=7, B=-3 (0xFFFFFFFD) -> done after 33 edges; HI=0xFFFFFFFF, LO=0xFFFFFFEB; mfhi returns 0xFFFFFFFF.
- div A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; a second start while busy is ignored and HI/LO reflect only the first operation.
- div A=5, B=0 -> LO=0xFFFFFFFF, HI=0x00000005 at full latency; div A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- mult 0x7FFFFFFF x 0x7FFFFFFF with reset asserted at iteration 10 -> IDLE next cycle, HI=LO=0, no done pulse.
- With MULDIV_FAST_MULT_EN, mult 0x80000000 x 0x80000000 -> done after 2 edges, HI=0x40000000, LO=0.
